gol_grid_engine: RTL and testbench

- Downstream consumer of the game-of-life control FSM's game_state output.
- Holds the ROWS x COLS toroidal cell grid and lets the user edit cells with btn0/btn1 while in PROGRAM.
- In RUN, computes one Conway generation per accepted gen_tick, evaluating one cell per cycle into a shadow buffer, then commits the whole grid in a single cycle.
- Drives the grid image to the display stage.

---
 rtl/gol_pkg.sv | 20 ++
 rtl/gol_next_cell.sv | 21 ++
 rtl/gol_grid_engine.sv | 175 +++++++++++++++++
 tb/tb_gol_grid_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared encodings and defaults for the game-of-life grid engine
package gol_pkg;

    typedef enum logic [1:0] {
        GS_IDLE    = 2'b00,
        GS_PROGRAM = 2'b01,
        GS_RUN     = 2'b10,
        GS_PAUSE   = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        E_WAIT   = 2'b00,
        E_SCAN   = 2'b01,
        E_COMMIT = 2'b10
    } engine_state_e;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

endpackage

// File: rtl/gol_next_cell.sv
// rtl/gol_next_cell.sv - next state of one cell from its centre bit and 8 neighbours
module gol_next_cell
    import gol_pkg::*;
(
    input  logic       centre,
    input  logic [7:0] nbrs,
    output logic       next
);

    logic [3:0] live_cnt;

    always_comb begin
        live_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            live_cnt = live_cnt + {3'b000, nbrs[i]};
        end
        // birth on exactly three, survival on two or three
        next = (live_cnt == 4'd3) || (centre && (live_cnt == 4'd2));
    end

endmodule

// File: rtl/gol_grid_engine.sv
// rtl/gol_grid_engine.sv - toroidal life grid with cursor editing and one-cell-per-cycle generation scan
module gol_grid_engine
    import gol_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int GCW  = 16
) (
    input  logic                          clka,
    input  logic                          stop,
    input  logic [1:0]                    game_state,
    input  logic                          btn0,
    input  logic                          btn1,
    input  logic                          gen_tick,
    output logic [ROWS*COLS-1:0]          grid,
    output logic [$clog2(ROWS*COLS)-1:0]  cursor,
    output logic                          busy,
    output logic                          gen_done,
    output logic [GCW-1:0]                gen_count
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic [N-1:0]    grid_q, grid_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [IW-1:0]   cursor_q, cursor_d;
    logic [GCW-1:0]  gen_count_q, gen_count_d;
    logic            busy_q, busy_d;
    logic            gen_done_q, gen_done_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            btn0_q, btn0_d;
    logic            btn1_q, btn1_d;
    engine_state_e   state_q, state_d;

    logic            btn0_rise, btn1_rise;
    logic [RW-1:0]   row_m, row_p;
    logic [CW-1:0]   col_m, col_p;
    logic [IW-1:0]   scan_idx;
    logic [7:0]      nbrs;
    logic            next_cell;

    function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(int'(r) * COLS + int'(c));
    endfunction

    assign btn0_rise = btn0 & ~btn0_q;
    assign btn1_rise = btn1 & ~btn1_q;

    // toroidal neighbour coordinates of the cell currently being scanned
    always_comb begin
        row_m    = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
        row_p    = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        col_m    = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
        col_p    = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        scan_idx = cell_idx(row_q, col_q);
        nbrs     = {grid_q[cell_idx(row_m, col_m)], grid_q[cell_idx(row_m, col_q)],
                    grid_q[cell_idx(row_m, col_p)], grid_q[cell_idx(row_q, col_m)],
                    grid_q[cell_idx(row_q, col_p)], grid_q[cell_idx(row_p, col_m)],
                    grid_q[cell_idx(row_p, col_q)], grid_q[cell_idx(row_p, col_p)]};
    end

    gol_next_cell u_next_cell (
        .centre (grid_q[scan_idx]),
        .nbrs   (nbrs),
        .next   (next_cell)
    );

    always_comb begin
        grid_d      = grid_q;
        shadow_d    = shadow_q;
        cursor_d    = cursor_q;
        gen_count_d = gen_count_q;
        busy_d      = busy_q;
        gen_done_d  = 1'b0;
        row_d       = row_q;
        col_d       = col_q;
        state_d     = state_q;
        btn0_d      = btn0;
        btn1_d      = btn1;

        if (game_state == GS_IDLE) begin
            grid_d      = '0;
            shadow_d    = '0;
            cursor_d    = '0;
            gen_count_d = '0;
            busy_d      = 1'b0;
            row_d       = '0;
            col_d       = '0;
            state_d     = E_WAIT;
        end else begin
            case (state_q)
                E_WAIT: begin
                    if (game_state == GS_PROGRAM) begin
                        if (btn1_rise) begin
                            grid_d[cursor_q] = ~grid_q[cursor_q];
                        end
                        if (btn0_rise) begin
                            cursor_d = (cursor_q == IW'(N - 1)) ? '0 : cursor_q + IW'(1);
                        end
                    end
                    if ((game_state == GS_RUN) && gen_tick) begin
                        state_d = E_SCAN;
                        busy_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                E_SCAN: begin
                    shadow_d[scan_idx] = next_cell;
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = E_COMMIT;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                E_COMMIT: begin
                    grid_d      = shadow_q;
                    gen_count_d = gen_count_q + GCW'(1);
                    gen_done_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = E_WAIT;
                end
                default: begin
                    state_d = E_WAIT;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (stop) begin
            grid_q      <= '0;
            shadow_q    <= '0;
            cursor_q    <= '0;
            gen_count_q <= '0;
            busy_q      <= 1'b0;
            gen_done_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            btn0_q      <= 1'b0;
            btn1_q      <= 1'b0;
            state_q     <= E_WAIT;
        end else begin
            grid_q      <= grid_d;
            shadow_q    <= shadow_d;
            cursor_q    <= cursor_d;
            gen_count_q <= gen_count_d;
            busy_q      <= busy_d;
            gen_done_q  <= gen_done_d;
            row_q       <= row_d;
            col_q       <= col_d;
            btn0_q      <= btn0_d;
            btn1_q      <= btn1_d;
            state_q     <= state_d;
        end
    end

    assign grid      = grid_q;
    assign cursor    = cursor_q;
    assign busy      = busy_q;
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_grid_engine.sv
// tb/tb_gol_grid_engine.sv - self-checking bench for gol_grid_engine against a whole-generation model
module tb_gol_grid_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        stop = 1'b1;
    logic [1:0]  game_state = 2'b10;
    logic        btn0 = 1'b0;
    logic        btn1 = 1'b0;
    logic        gen_tick = 1'b1;
    logic [N-1:0] grid;
    logic [5:0]  cursor;
    logic        busy;
    logic        gen_done;
    logic [15:0] gen_count;

    int n_chk = 0;
    int n_err = 0;
    int tb_cur = 0;

    always #5 clk = ~clk;

    gol_grid_engine #(.ROWS(ROWS), .COLS(COLS), .GCW(16)) dut (
        .clka       (clk),
        .stop       (stop),
        .game_state (game_state),
        .btn0       (btn0),
        .btn1       (btn1),
        .gen_tick   (gen_tick),
        .grid       (grid),
        .cursor     (cursor),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-generation model: next grid from plain modular arithmetic over rows/cols
    function automatic logic [N-1:0] life(input logic [N-1:0] g);
        logic [N-1:0] nx;
        nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + ROWS) % ROWS) * COLS + ((c + dc + COLS) % COLS)]);
                    end
                end
                nx[r * COLS + c] = (cnt == 3) || (g[r * COLS + c] && cnt == 2);
            end
        end
        return nx;
    endfunction

    logic [N-1:0] m_grid = '0, m_pending = '0;
    int           m_cursor = 0;
    int           m_timer = 0;
    logic [15:0]  m_count = '0;
    logic         m_busy = 1'b0, m_done = 1'b0;
    logic         m_b0_prev = 1'b0, m_b1_prev = 1'b0;
    logic         m_valid = 1'b0;
    wire          m_b0_rise = btn0 & ~m_b0_prev;
    wire          m_b1_rise = btn1 & ~m_b1_prev;

    always @(posedge clk) begin
        m_done    <= 1'b0;
        m_b0_prev <= btn0;
        m_b1_prev <= btn1;
        if (stop) begin
            m_valid <= 1'b1;
            m_grid <= '0; m_cursor <= 0; m_count <= '0; m_busy <= 1'b0; m_timer <= 0;
            m_b0_prev <= 1'b0; m_b1_prev <= 1'b0;
        end else if (game_state == 2'b00) begin
            m_grid <= '0; m_cursor <= 0; m_count <= '0; m_busy <= 1'b0; m_timer <= 0;
        end else if (m_busy) begin
            if (m_timer == 1) begin
                m_grid  <= m_pending;
                m_count <= m_count + 16'd1;
                m_done  <= 1'b1;
                m_busy  <= 1'b0;
                m_timer <= 0;
            end else begin
                m_timer <= m_timer - 1;
            end
        end else begin
            if (game_state == 2'b01) begin
                if (m_b1_rise) m_grid[m_cursor] <= ~m_grid[m_cursor];
                if (m_b0_rise) m_cursor <= (m_cursor + 1) % N;
            end
            if (game_state == 2'b10 && gen_tick) begin
                m_pending <= life(m_grid);
                m_busy    <= 1'b1;
                m_timer   <= N + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_grid",      64'(grid),      64'(m_grid));
            check("cyc_cursor",    64'(cursor),    64'(m_cursor));
            check("cyc_busy",      64'(busy),      64'(m_busy));
            check("cyc_gen_done",  64'(gen_done),  64'(m_done));
            check("cyc_gen_count", 64'(gen_count), 64'(m_count));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press0();
        btn0 = 1'b1; step();
        btn0 = 1'b0; step();
        tb_cur = (tb_cur + 1) % N;
    endtask

    task automatic press1();
        btn1 = 1'b1; step();
        btn1 = 1'b0; step();
    endtask

    task automatic goto_cell(input int t);
        while (tb_cur != t) press0();
    endtask

    task automatic run_gen(input int tick_at, input int pause_at, input int idle_at,
                           output int edges, output bit saw_done);
        game_state = 2'b10;
        gen_tick = 1'b1;
        step();
        gen_tick = 1'b0;
        edges = 0;
        saw_done = 1'b0;
        while (busy && edges < 200) begin
            gen_tick = (edges == tick_at);
            if (edges == pause_at) game_state = 2'b11;
            if (edges == idle_at)  game_state = 2'b00;
            step();
            edges++;
            if (gen_done) saw_done = 1'b1;
        end
        gen_tick = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  saw;

        step(); step();
        check("rst_grid",      64'(grid),      64'h0);
        check("rst_cursor",    64'(cursor),    64'h0);
        check("rst_gen_count", 64'(gen_count), 64'h0);
        check("rst_busy",      64'(busy),      64'h0);
        check("rst_gen_done",  64'(gen_done),  64'h0);

        stop = 1'b0; game_state = 2'b01; gen_tick = 1'b0;
        step();

        btn1 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        btn1 = 1'b0; step();
        check("held_btn1_toggle_once", 64'(grid), 64'h1);

        for (int i = 0; i < 9; i++) press0();
        check("cursor_nine", 64'(cursor), 64'd9);

        btn0 = 1'b1; btn1 = 1'b1; step();
        btn0 = 1'b0; btn1 = 1'b0; step();
        tb_cur = 10;
        check("both_grid",   64'(grid),   64'h201);
        check("both_cursor", 64'(cursor), 64'd10);

        for (int i = 0; i < 64; i++) press0();
        check("cursor_wrap", 64'(cursor), 64'd10);

        game_state = 2'b00; step();
        tb_cur = 0;
        check("idle_grid",   64'(grid),   64'h0);
        check("idle_cursor", 64'(cursor), 64'h0);

        game_state = 2'b01;
        goto_cell(26); press1();
        goto_cell(27); press1();
        goto_cell(28); press1();
        check("blinker_prog", 64'(grid), 64'h0000_0000_1C00_0000);

        run_gen(10, 20, -1, edges, saw);
        check("blinker_busy_len", 64'(edges), 64'd65);
        check("blinker_done_seen", 64'(saw), 64'd1);
        check("blinker_done_now", 64'(gen_done), 64'd1);
        check("blinker_vertical", 64'(grid), 64'h0000_0008_0808_0000);
        check("blinker_count1", 64'(gen_count), 64'd1);

        gen_tick = 1'b1; step();
        gen_tick = 1'b0;
        check("pause_tick_busy", 64'(busy), 64'd0);
        step();

        run_gen(-1, -1, -1, edges, saw);
        check("blinker2_busy_len", 64'(edges), 64'd65);
        check("blinker_horizontal", 64'(grid), 64'h0000_0000_1C00_0000);
        check("blinker_count2", 64'(gen_count), 64'd2);

        game_state = 2'b00; step();
        tb_cur = 0;
        game_state = 2'b01;
        press1();
        goto_cell(1); press1();
        goto_cell(7); press1();
        check("wrap_prog", 64'(grid), 64'h83);
        run_gen(-1, -1, -1, edges, saw);
        check("wrap_result", 64'(grid), 64'h0100_0000_0000_0101);
        check("wrap_count", 64'(gen_count), 64'd1);

        run_gen(-1, -1, 30, edges, saw);
        check("abort_busy_len", 64'(edges), 64'd31);
        check("abort_no_done", 64'(saw), 64'd0);
        check("abort_grid", 64'(grid), 64'h0);
        check("abort_count", 64'(gen_count), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
